// File: rtl/display_scanner.sv
// Four-digit seven-segment scan controller: frame-snapshotted hours/minutes, guard-banded anodes.
// Optional digit blinking for set mode is compiled in with `define DISPLAY_BLINK_EN.
module display_scanner #(
  parameter int unsigned REFRESH_DIV = 25000,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic       set24hours,
  input  logic       blinkHours,
  input  logic       blinkMinutes,
  output logic [3:0] an,
  output logic [5:0] number,
  output logic       tens,
  output logic       hoursPlace,
  output logic       dp
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);

  typedef enum logic [1:0] {
    SLOT_MIN_ONES = 2'd0,
    SLOT_MIN_TENS = 2'd1,
    SLOT_HR_ONES  = 2'd2,
    SLOT_HR_TENS  = 2'd3
  } slot_t;

  logic [PW-1:0] presc, presc_next;
  slot_t         idx, idx_next;
  logic [5:0]    hours_q, minutes_q, hours_next, minutes_next;
  logic          slot_wrap, frame_wrap;
  logic          blank_hr, blank_min;
  logic [3:0]    an_next;
  logic          dp_next;
  logic [5:0]    number_next;
  logic          tens_next, hours_place_next;

  // Registered outputs are derived from next-state values so they move on the same edge as idx.
  always_comb begin
    slot_wrap    = (presc == PRESC_LAST);
    presc_next   = slot_wrap ? '0 : presc + 1'b1;
    idx_next     = slot_wrap ? slot_t'(idx + 2'd1) : idx;
    frame_wrap   = slot_wrap && (idx == SLOT_HR_TENS);
    hours_next   = frame_wrap ? hours   : hours_q;
    minutes_next = frame_wrap ? minutes : minutes_q;
  end

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase, blink_phase_next;

  always_comb begin
    blink_phase_next = (blink_cnt == BLINK_LAST) ? ~blink_phase : blink_phase;
    blank_hr         = blink_phase_next & blinkHours;
    blank_min        = blink_phase_next & blinkMinutes;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase_next;
    end
  end
`else
  logic unused_blink;

  assign unused_blink = ^{blinkHours, blinkMinutes} ^ (BLINK_DIV == 0);
  assign blank_hr     = 1'b0;
  assign blank_min    = 1'b0;
`endif

  always_comb begin
    an_next = '1;
    if (presc_next >= GUARD_END) begin
      an_next = ~(4'b0001 << idx_next);
      if (blank_hr)  an_next[3:2] = 2'b11;
      if (blank_min) an_next[1:0] = 2'b11;
    end
    dp_next = ~((idx_next == SLOT_MIN_ONES) && (presc_next >= GUARD_END) &&
                !set24hours && (hours_next >= 6'd12));
    number_next      = minutes_next;
    tens_next        = 1'b0;
    hours_place_next = 1'b0;
    case (idx_next)
      SLOT_MIN_ONES: begin
        number_next = minutes_next;
      end
      SLOT_MIN_TENS: begin
        number_next = minutes_next;
        tens_next   = 1'b1;
      end
      SLOT_HR_ONES: begin
        number_next      = hours_next;
        hours_place_next = 1'b1;
      end
      SLOT_HR_TENS: begin
        number_next      = hours_next;
        tens_next        = 1'b1;
        hours_place_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      idx        <= SLOT_MIN_ONES;
      hours_q    <= '0;
      minutes_q  <= '0;
      an         <= '1;
      dp         <= 1'b1;
      number     <= '0;
      tens       <= 1'b0;
      hoursPlace <= 1'b0;
    end else begin
      presc      <= presc_next;
      idx        <= idx_next;
      hours_q    <= hours_next;
      minutes_q  <= minutes_next;
      an         <= an_next;
      dp         <= dp_next;
      number     <= number_next;
      tens       <= tens_next;
      hoursPlace <= hours_place_next;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner with REFRESH_DIV=4, GUARD=1, BLINK_DIV=8.
// Expected values come from a cycle-count model (edges since reset release).
module tb_display_scanner;

  logic       clk;
  logic       reset_n;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic       set24hours;
  logic       blinkHours;
  logic       blinkMinutes;
  logic [3:0] an;
  logic [5:0] number;
  logic       tens;
  logic       hoursPlace;
  logic       dp;

  display_scanner #(
    .REFRESH_DIV(4),
    .GUARD      (1),
    .BLINK_DIV  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hours       (hours),
    .minutes     (minutes),
    .set24hours  (set24hours),
    .blinkHours  (blinkHours),
    .blinkMinutes(blinkMinutes),
    .an          (an),
    .number      (number),
    .tens        (tens),
    .hoursPlace  (hoursPlace),
    .dp          (dp)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [5:0] number;
    logic       tens;
    logic       hp;
    logic       dp;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors;
  int unsigned miscompares;

  int unsigned t;
  int unsigned m_presc;
  int unsigned m_slot;
  int unsigned m_phase;
  logic [5:0]  snap_h;
  logic [5:0]  snap_m;
  exp_t        m_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: state after t rising edges since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t      = 0;
      snap_h = '0;
      snap_m = '0;
      if (clk) begin
        m_exp = '{4'hF, 6'd0, 1'b0, 1'b0, 1'b1};
        sb.push_back(m_exp);
      end
    end else begin
      t = t + 1;
      if (t % 16 == 0) begin
        snap_h = hours;
        snap_m = minutes;
      end
      m_presc = t % 4;
      m_slot  = (t / 4) % 4;
      m_phase = (t / 8) % 2;
      m_exp.number = (m_slot >= 2) ? snap_h : snap_m;
      m_exp.tens   = (m_slot == 1 || m_slot == 3);
      m_exp.hp     = (m_slot >= 2);
      if (m_presc == 0) begin
        m_exp.an = 4'hF;
      end else begin
        m_exp.an = ~(4'b0001 << m_slot);
`ifdef DISPLAY_BLINK_EN
        if (m_phase == 1 && blinkHours)   m_exp.an[3:2] = 2'b11;
        if (m_phase == 1 && blinkMinutes) m_exp.an[1:0] = 2'b11;
`endif
      end
      m_exp.dp = (m_slot == 0 && m_presc != 0 && !set24hours && snap_h >= 6'd12) ? 1'b0 : 1'b1;
      sb.push_back(m_exp);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors = vectors + 1;
    if (got !== want) begin
      miscompares = miscompares + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  task automatic tick(input int unsigned n);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("sb_depth", sb.size(), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("an", {28'd0, an}, {28'd0, e.an});
        check_val("number", {26'd0, number}, {26'd0, e.number});
        check_val("tens", {31'd0, tens}, {31'd0, e.tens});
        check_val("hoursPlace", {31'd0, hoursPlace}, {31'd0, e.hp});
        check_val("dp", {31'd0, dp}, {31'd0, e.dp});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset_n      = 1'b0;
    hours        = 6'd13;
    minutes      = 6'd45;
    set24hours   = 1'b0;
    blinkHours   = 1'b0;
    blinkMinutes = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(32);
    // Mid slot 1: the new minute must wait for the next frame.
    tick(6);
    minutes = 6'd46;
    tick(30);
    set24hours = 1'b1;
    tick(16);
    set24hours = 1'b0;
    hours      = 6'd11;
    tick(32);
    hours = 6'd13;
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_an", {28'd0, an}, 32'hF);
    check_val("async_number", {26'd0, number}, 32'd0);
    check_val("async_tens", {31'd0, tens}, 32'd0);
    check_val("async_hp", {31'd0, hoursPlace}, 32'd0);
    check_val("async_dp", {31'd0, dp}, 32'd1);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    blinkHours = 1'b1;
    tick(48);
    blinkMinutes = 1'b1;
    tick(32);
    blinkHours   = 1'b0;
    blinkMinutes = 1'b0;
    tick(8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
